// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR sequencer - sample handshake, tap address walk and MAC enables.
// Define FIR_CTRL_FLUSH_EN to drain the filter tail with zero samples after in_last.
module fir_ctrl #(
  parameter int TAPS   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              clr_req,
  output logic              nowa_shift,
  output logic              reset_shift,
  output logic              zero_sel,
  output logic [ADDR_W-1:0] adres,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_last,
  output logic              done,
  output logic              busy
);
`ifdef FIR_CTRL_FLUSH_EN
  typedef enum logic [2:0] {IDLE, MAC, DONE, CLEAR, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, MAC, DONE, CLEAR} state_t;
`endif
  localparam logic [ADDR_W-1:0] last = ADDR_W'(TAPS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] tap_cnt;
  logic hs;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      tap_cnt <= '0;
    end else begin
      state   <= state_n;
      tap_cnt <= (state == MAC && tap_cnt != last) ? tap_cnt + 1'b1 : '0;
    end
`ifdef FIR_CTRL_FLUSH_EN
  // Non-zero flush_cnt doubles as the flush-pending flag.
  logic [ADDR_W-1:0] flush_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) flush_cnt <= '0;
    else if (hs && in_last) flush_cnt <= last;
    else if (state == FLUSH) flush_cnt <= flush_cnt - 1'b1;
`else
  logic unused_last;
  assign unused_last = in_last;
`endif
  always_comb begin
    in_ready    = !rst && state == IDLE && !clr_req;
    hs          = in_valid && in_ready;
    mac_en      = state == MAC;
    adres       = mac_en ? tap_cnt : '0;
    mac_first   = mac_en && tap_cnt == '0;
    mac_last    = mac_en && tap_cnt == last;
    done        = state == DONE;
    reset_shift = state == CLEAR;
    busy        = state != IDLE;
`ifdef FIR_CTRL_FLUSH_EN
    zero_sel    = state == FLUSH;
`else
    zero_sel    = 1'b0;
`endif
    nowa_shift  = hs || zero_sel;
    state_n     = state;
    case (state)
      IDLE:    state_n = clr_req ? CLEAR : hs ? MAC : IDLE;
      MAC:     state_n = mac_last ? DONE : MAC;
`ifdef FIR_CTRL_FLUSH_EN
      DONE:    state_n = flush_cnt != '0 ? FLUSH : IDLE;
      FLUSH:   state_n = MAC;
`else
      DONE:    state_n = IDLE;
`endif
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed and random checks of fir_ctrl against a cycle-timeline model.
module tb_fir_ctrl;
`ifdef FIR_CTRL_FLUSH_EN
  localparam int TAPS = 4;
`else
  localparam int TAPS = 32;
`endif
  localparam int AW = $clog2(TAPS);
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, clr_req = 0;
  logic in_ready, nowa_shift, reset_shift, zero_sel, mac_en, mac_first, mac_last, done, busy;
  logic [AW-1:0] adres;
  int n_chk = 0, n_fail = 0;
  int t = -1, clr_t = -1, fl = 0;
  int hs_cnt = 0, done_cnt = 0, zero_cnt = 0, base;
  always #5 clk = ~clk;
  fir_ctrl #(.TAPS(TAPS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .clr_req(clr_req), .nowa_shift(nowa_shift), .reset_shift(reset_shift), .zero_sel(zero_sel),
    .adres(adres), .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
    .done(done), .busy(busy)
  );
  function automatic logic [AW+8:0] outs();
    return {in_ready, nowa_shift, reset_shift, zero_sel, mac_en, mac_first, mac_last, done, busy, adres};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // t: cycles since the handshake (-1 idle, 0 a zero-sample flush cycle); clr_t: clear strobe pending.
  task automatic step(logic v, logic l, logic c);
    logic [AW+8:0] e;
    logic idle, rdy, hs, in_mac;
    in_valid = v; in_last = l; clr_req = c;
    @(negedge clk);
    idle   = t < 0 && clr_t < 0;
    rdy    = idle && !c;
    hs     = rdy && v;
    in_mac = t >= 1 && t <= TAPS;
    e = {rdy, hs || t == 0, clr_t == 1, t == 0, in_mac, t == 1, t == TAPS, t == TAPS + 1, !idle,
         AW'(in_mac ? t - 1 : 0)};
    chk("outs", outs(), e);
    if (done) done_cnt++;
    if (zero_sel && nowa_shift) zero_cnt++;
    if (in_valid && in_ready) hs_cnt++;
    @(posedge clk); #1;
    if (t == TAPS + 1) t = fl > 0 ? 0 : -1;
    else if (t == 0) begin fl--; t = 1; end
    else if (t >= 1) t++;
    else if (hs) begin
      t = 1;
`ifdef FIR_CTRL_FLUSH_EN
      if (l) fl = TAPS - 1;
`endif
    end
    if (clr_t == 1) clr_t = -1;
    else if (idle && c) clr_t = 1;
  endtask
  initial begin
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", outs(), 0);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    #1 chk("ready_after_reset", {in_ready, busy}, 2'b10);
    step(1, 0, 0);
    repeat (TAPS + 1) step(0, 0, 0);
    chk("single_done", done_cnt, 1);
    base = hs_cnt;
    repeat (3 * (TAPS + 2)) step(1, 0, 0);
    chk("b2b_handshakes", hs_cnt - base, 3);
    repeat (TAPS + 2) step(0, 0, 0);
    base = hs_cnt;
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (TAPS + 1) step(0, 0, 0);
    chk("clear_then_accept", hs_cnt - base, 1);
    step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    chk("adres_before_rst", adres, 10 % TAPS);
    base = done_cnt;
    rst = 1;
    #1 chk("async_rst_outs", outs(), 0);
    t = -1; clr_t = -1; fl = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (TAPS + 4) step(0, 0, 0);
    chk("no_done_after_rst", done_cnt - base, 0);
    step(1, 0, 0);
    repeat (TAPS + 1) step(0, 0, 0);
`ifdef FIR_CTRL_FLUSH_EN
    base = done_cnt;
    step(1, 0, 0);
    repeat (TAPS + 1) step(0, 0, 0);
    step(1, 1, 0);
    repeat (TAPS * (TAPS + 2)) step(1, 0, 0);
    chk("flush_dones", done_cnt - base, TAPS + 1);
    chk("flush_zero_shifts", zero_cnt, TAPS - 1);
    repeat (TAPS + 1) step(0, 0, 0);
`endif
    repeat (3000) step($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencer for the FIR datapath: accepts one input sample per handshake, commands the 32-tap sample shift register to take it, then walks the tap address across all taps while driving the MAC enables. One filter output is produced per accepted sample. The block sits between the input sample source (RAM/stream) and the shift register, coefficient ROM and MAC. It owns `nowa_shift`, `reset_shift` and `adres` for the shift register.

## Interface
- `TAPS`, 32: number of filter taps; must be a power of two, 2..32.
- `ADDR_W`, 5: tap address width, equal to log2(TAPS).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream has a sample on the shift register's `probka_in`.
- `in_last` in 1: qualifies `in_valid`; marks the final sample of a stream.
- `in_ready` out 1: controller can accept a sample this cycle.
- `clr_req` in 1: request to zero the shift register contents.
- `nowa_shift` out 1: shift-register load strobe.
- `reset_shift` out 1: shift-register clear strobe.
- `zero_sel` out 1: selects 0 into `probka_in` (flush samples).
- `adres` out ADDR_W: tap address to the shift register, also used as the coefficient ROM address.
- `mac_en` out 1: MAC accumulates `out*coef` this cycle.
- `mac_first` out 1: first product; MAC loads instead of adding.
- `mac_last` out 1: last product of the current output.
- `done` out 1: one-cycle pulse after each completed output.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, MAC, DONE, CLEAR, and FLUSH when the flush feature is compiled in. The state register is the only sequential source apart from the counters `tap_cnt` (ADDR_W) and `flush_cnt` (ADDR_W).
- **IDLE**
  - `in_ready = !clr_req`.
  - `nowa_shift = in_valid & in_ready`, combinational, so the shift register captures in the handshake cycle.
  - On a handshake: go to MAC with `tap_cnt = 0`.
  - On `clr_req`: go to CLEAR. Clear wins over a simultaneous `in_valid`; no handshake occurs in that cycle.
- **MAC**
  - `adres = tap_cnt`, `mac_en = 1`.
  - `mac_first = (tap_cnt == 0)`, `mac_last = (tap_cnt == TAPS-1)`.
  - `tap_cnt` increments each cycle. At TAPS-1 it wraps to 0 and the state goes to DONE.
- **DONE**
  - `done = 1` for one cycle.
  - Next state: FLUSH if a flush is pending, otherwise IDLE.
- **CLEAR**
  - `reset_shift = 1` for one cycle, then IDLE.
- `in_valid`, `in_last` and `clr_req` are ignored outside IDLE; `in_ready = 0` there.
- `adres` is 0 whenever the state is not MAC.
- Reset mid-operation: the state machine returns to IDLE immediately and the counters clear.
  - The partial MAC result is abandoned; no `done` is issued.
  - Shift-register contents are not cleared by this block.

## Timing
- While `rst` is high, all outputs are 0, including `in_ready`. `adres = 0`.
- The handshake is in cycle 0. MAC runs cycles 1..TAPS; `mac_first` is in cycle 1 and `mac_last` in cycle TAPS.
- `done` is in cycle TAPS+1. `in_ready` can rise again in cycle TAPS+2.
- Throughput: one sample per TAPS+2 cycles.
- Shift-register read is combinational. `adres`, `mac_en` and the sample are therefore aligned in the same cycle. Any ROM latency is absorbed downstream.
- `clr_req` in IDLE gives `reset_shift` in the next cycle; `in_ready` returns the cycle after that.

## Configuration
- Macro: `FIR_CTRL_FLUSH_EN`.
- **Defined:**
  - A handshake with `in_last = 1` sets a flush pending, with `flush_cnt = TAPS-1`.
  - After that sample's DONE, the controller enters FLUSH. There it drives `nowa_shift = 1` and `zero_sel = 1` for one cycle, decrements `flush_cnt`, then runs MAC and DONE as normal.
  - This repeats until `flush_cnt` reaches 0. The result is TAPS-1 extra outputs that drain the filter tail. `in_ready = 0` throughout.
  - `rst` cancels a pending flush.
- **Undefined:** `in_last` is ignored, `zero_sel` is tied to 0, the FLUSH state does not exist, and `flush_cnt` is not built.

## Test plan
- Reset: hold `rst` for 3 cycles, then release with `in_valid = 0` → all outputs 0 during reset; `in_ready = 1` and `busy = 0` after release.
- Single sample, TAPS=32: handshake at cycle 0 → `nowa_shift` in cycle 0; `adres` counts 0..31 in cycles 1..32; `mac_first` only in cycle 1, `mac_last` only in cycle 32; `done` in cycle 33; `in_ready` in cycle 34.
- Back-to-back samples with `in_valid` held high → handshakes exactly 34 cycles apart; no `nowa_shift` while `busy = 1`.
- `clr_req` and `in_valid` both asserted in IDLE → no handshake; `reset_shift` pulses once next cycle; sample accepted 2 cycles later.
- `rst` asserted at `adres = 10` → outputs 0 asynchronously; no `done`; after release, a fresh sample restarts at `adres = 0`.
- `FIR_CTRL_FLUSH_EN`, TAPS=4: stream of 2 samples with `in_last` on the second → 5 `done` pulses total; 3 zero-sample shifts with `zero_sel = 1`; `in_ready` low until after the 5th `done`.
